hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It drives the hold/bubble/flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use and taken-branch hazards, and sequences the request/acknowledge handshake to the multi-cycle data memory, freezing the pipeline until the access completes. It also keeps a sticky timeout error and a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl_if.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Data-memory handshake between the hazard/stall controller and the data memory.
//   mem_req : controller -> memory, request, level-held until acknowledged
//   mem_we  : controller -> memory, write enable, valid while mem_req is 1
//   mem_ack : memory -> controller, completes the outstanding access
// master modport is the controller side, slave modport is the memory side.
interface hazard_stall_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Detects load-use and taken-branch hazards and sequences the data-memory
// request/acknowledge handshake, freezing the pipeline while an access is
// outstanding. Keeps a sticky memory-timeout flag and a saturating count of
// stalled cycles.
// Ports:
//   clk_i, start_i          clock, asynchronous active-low reset
//   IFID_RS1addr_i/RS2      source registers of the instruction in ID
//   IDEX_MemRead_i, RDaddr  load in EX and its destination register
//   Branch_taken_i          branch in ID resolved taken
//   EXMEM_MemRead/Write_i   instruction in MEM accesses data memory
//   mem (master)            data-memory req/we/ack handshake
//   PCWrite_o, IFIDWrite_o  1 = register loads, 0 = holds
//   IFIDFlush_o             IF/ID loads a NOP
//   IDEXenable_o            1 = ID/EX holds its contents
//   IDEXBubble_o            ID/EX loads zeroed control fields
//   EXMEMHold_o             EX/MEM holds its contents
//   err_o                   sticky memory-timeout flag
//   stall_cnt_o             saturating stalled-cycle count
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic                clk_i,
    input  logic                start_i,
    input  logic [4:0]          IFID_RS1addr_i,
    input  logic [4:0]          IFID_RS2addr_i,
    input  logic                IDEX_MemRead_i,
    input  logic [4:0]          IDEX_RDaddr_i,
    input  logic                Branch_taken_i,
    input  logic                EXMEM_MemRead_i,
    input  logic                EXMEM_MemWrite_i,
    hazard_stall_ctrl_if.master mem,
    output logic                PCWrite_o,
    output logic                IFIDWrite_o,
    output logic                IFIDFlush_o,
    output logic                IDEXenable_o,
    output logic                IDEXBubble_o,
    output logic                EXMEMHold_o,
    output logic                err_o,
    output logic [31:0]         stall_cnt_o
);

    localparam logic [TO_W-1:0] TimeoutLimit = TO_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              err_q, err_d;
    logic [31:0]       stall_q, stall_d;

    logic acc;
    logic busy;
    logic req;
    logic mstall;
    logic lu;

    assign acc  = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign busy = (state_q == StBusy);
    assign req  = ((state_q == StIdle) & acc) | busy;
    // The ack cycle itself is not a stall: the pipeline advances at its end.
    assign mstall = req & ~(busy & mem.mem_ack);
    assign lu = IDEX_MemRead_i & (IDEX_RDaddr_i != 5'd0) &
                ((IDEX_RDaddr_i == IFID_RS1addr_i) | (IDEX_RDaddr_i == IFID_RS2addr_i));

    // Outputs are forced to their reset values while start_i is low, so an
    // access held in MEM does not keep requesting during reset.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IFIDFlush_o  = 1'b0;
        IDEXenable_o = 1'b0;
        IDEXBubble_o = 1'b0;
        EXMEMHold_o  = 1'b0;
        if (start_i) begin
            mem.mem_req = req;
            mem.mem_we  = req & EXMEM_MemWrite_i;
            if (mstall) begin
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IDEXenable_o = 1'b1;
                EXMEMHold_o  = 1'b1;
            end else if (lu) begin
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IDEXBubble_o = 1'b1;
            end else begin
                // Branch operands are invalid under load-use, hence the ordering.
                IFIDFlush_o = Branch_taken_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        err_d   = err_q;
        stall_d = stall_q;

        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    state_d = StBusy;
                    to_d    = '0;
                end
            end
            StBusy: begin
                if (mem.mem_ack) begin
                    state_d = StIdle;
                end else if (to_q != TimeoutLimit) begin
                    // Stay frozen in BUSY on timeout; only the flag reports it.
                    to_d = to_q + TO_W'(1);
                    if (to_d == TimeoutLimit) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if ((mstall | lu) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= StIdle;
            to_q    <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign err_o       = err_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT = 8).
// Each cycle drives inputs, queues the expected control vector
// {req, we, PCWrite, IFIDWrite, IFIDFlush, IDEXenable, IDEXBubble, EXMEMHold}
// and compares it mid-cycle against the DUT.
module tb_hazard_stall_ctrl;

    localparam logic [7:0] Free   = 8'b0011_0000;
    localparam logic [7:0] MstRd  = 8'b1000_0101;
    localparam logic [7:0] MstWr  = 8'b1100_0101;
    localparam logic [7:0] LdUse  = 8'b0000_0010;
    localparam logic [7:0] Flush  = 8'b0011_1000;
    localparam logic [7:0] AckRd  = 8'b1011_0000;
    localparam logic [7:0] AckRdF = 8'b1011_1000;
    localparam logic [7:0] AckWr  = 8'b1111_0000;

    logic        clk_i = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        idex_mr = 1'b0, br = 1'b0, ex_mr = 1'b0, ex_mw = 1'b0;
    logic        pcw, ifw, flush, idexen, bubble, hold, err;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    hazard_stall_ctrl_if mif ();

    hazard_stall_ctrl #(
        .MEM_TIMEOUT(8),
        .TO_W       (8)
    ) dut (
        .clk_i           (clk_i),
        .start_i         (start_i),
        .IFID_RS1addr_i  (rs1),
        .IFID_RS2addr_i  (rs2),
        .IDEX_MemRead_i  (idex_mr),
        .IDEX_RDaddr_i   (rd),
        .Branch_taken_i  (br),
        .EXMEM_MemRead_i (ex_mr),
        .EXMEM_MemWrite_i(ex_mw),
        .mem             (mif.master),
        .PCWrite_o       (pcw),
        .IFIDWrite_o     (ifw),
        .IFIDFlush_o     (flush),
        .IDEXenable_o    (idexen),
        .IDEXBubble_o    (bubble),
        .EXMEMHold_o     (hold),
        .err_o           (err),
        .stall_cnt_o     (stall_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {mif.mem_req, mif.mem_we, pcw, ifw, flush, idexen, bubble, hold};
    endfunction

    task automatic compare_ctrl(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, ctrl_vec()}, {24'd0, e});
        end
    endtask

    // Entered and left at posedge+1; compares at posedge+5 (mid-cycle).
    task automatic run_cycle(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                             input logic lmr, input logic [4:0] d, input logic b,
                             input logic mr, input logic mw, input logic ack,
                             input logic [7:0] exp);
        rs1 = a1; rs2 = a2; idex_mr = lmr; rd = d; br = b;
        ex_mr = mr; ex_mw = mw; mif.mem_ack = ack;
        exp_q.push_back(exp);
        #4;
        compare_ctrl(tag);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        mif.mem_ack = 1'b0;
        // Reset held with a load sitting in MEM: no request may leak out.
        ex_mr = 1'b1;
        #12;
        exp_q.push_back(Free);
        compare_ctrl("rst_outputs");
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk_i);
        #1;
        ex_mr = 1'b0;
        start_i = 1'b1;

        // Load-use via rs2, via rs1, then rd = x0 never stalls.
        run_cycle("lu_rs2",      5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LdUse);
        run_cycle("lu_after",    5'd3, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, Free);
        run_cycle("lu_rs1",      5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LdUse);
        run_cycle("lu_x0",       5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, Free);
        run_cycle("lu_nomatch",  5'd1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, Free);
        check("stall_cnt_lu", stall_cnt, 32'd2);

        // Branch with load-use: bubble only. Branch alone: flush.
        run_cycle("br_lu",       5'd4, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, LdUse);
        run_cycle("br_flush",    5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, Flush);
        check("stall_cnt_br", stall_cnt, 32'd3);

        // Load in MEM, ack four cycles after the request; branch during stall.
        run_cycle("ld_t0",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MstRd);
        run_cycle("ld_t1",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MstRd);
        run_cycle("ld_t2_br",    5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, MstRd);
        run_cycle("ld_t3",       5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, MstRd);
        run_cycle("ld_ack_br",   5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, AckRdF);
        run_cycle("ld_idle",     5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, Free);
        check("stall_cnt_ld", stall_cnt, 32'd7);

        // Back-to-back loads, each acked two cycles after its request.
        // The ack in the idle cycle must be ignored.
        run_cycle("b2b_a0",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, MstRd);
        run_cycle("b2b_a1",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MstRd);
        run_cycle("b2b_a_ack",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, AckRd);
        run_cycle("b2b_b0",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MstRd);
        run_cycle("b2b_b1",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, MstRd);
        run_cycle("b2b_b_ack",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, AckRd);
        run_cycle("b2b_idle",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, Free);
        check("stall_cnt_b2b", stall_cnt, 32'd11);

        // Reset asserted mid-cycle during BUSY, store still in MEM.
        run_cycle("st_t0",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MstWr);
        run_cycle("st_t1",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MstWr);
        start_i = 1'b0;
        #1;
        exp_q.push_back(Free);
        compare_ctrl("rst_busy_outputs");
        check("rst_busy_stall_cnt", stall_cnt, 32'd0);
        check("rst_busy_err", {31'd0, err}, 32'd0);
        #1;
        start_i = 1'b1;
        run_cycle("st_reissue",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MstWr);
        run_cycle("st_ack",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, AckWr);
        run_cycle("st_idle",     5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, Free);
        check("stall_cnt_rst", stall_cnt, 32'd1);

        // Store never acknowledged: err rises after 8 BUSY cycles, pipeline frozen.
        run_cycle("to_req",      5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MstWr);
        for (int k = 1; k <= 12; k++) begin
            run_cycle("to_busy", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MstWr);
            check($sformatf("to_err_%0d", k), {31'd0, err}, {31'd0, (k >= 8)});
        end
        check("stall_cnt_to", stall_cnt, 32'd14);
        run_cycle("to_late_ack", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, AckWr);
        run_cycle("to_idle",     5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, Free);
        check("err_sticky", {31'd0, err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
